byte_bus_arbiter: RTL and testbench

- Shares the single 8-bit external byte bus (uo_out / uio_out / uio_in / uio_oe) between two 32-bit requesters, e.g. the CPU core and a debug/DMA port.
- Round-robin arbitration; the winner's transaction is sequenced as 4 address bytes out, then 4 data bytes out (write) or in (read).
- Sits between the requesters and the top-level pins; replaces ad-hoc phase counting in the top module.

---
 rtl/byte_bus_if.sv | 52 +++++
 rtl/byte_bus_arbiter.sv | 132 +++++++++++++
 tb/tb_byte_bus_arbiter.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/byte_bus_if.sv
// Requester and external byte-bus signal bundle for byte_bus_arbiter.
// Optional bus_rdy wait input exists only when BYTE_BUS_WAIT_EN is defined.
interface byte_bus_if #(
    parameter int BEATS = 4
);
    localparam int W = 8 * BEATS;

    logic         req0;
    logic         rw0;
    logic [W-1:0] addr0;
    logic [W-1:0] wdata0;
    logic         ack0;
    logic         req1;
    logic         rw1;
    logic [W-1:0] addr1;
    logic [W-1:0] wdata1;
    logic         ack1;
    logic [W-1:0] rdata;
    logic [7:0]   bus_out;
    logic [7:0]   bus_oe;
    logic [7:0]   bus_in;
    logic [3:0]   bus_phase;
    logic [1:0]   grant;
    logic         busy;
`ifdef BYTE_BUS_WAIT_EN
    logic         bus_rdy;
`endif

    modport master (
        input  req0, rw0, addr0, wdata0,
        input  req1, rw1, addr1, wdata1,
        input  bus_in,
`ifdef BYTE_BUS_WAIT_EN
        input  bus_rdy,
`endif
        output ack0, ack1, rdata,
        output bus_out, bus_oe, bus_phase,
        output grant, busy
    );

    modport slave (
        output req0, rw0, addr0, wdata0,
        output req1, rw1, addr1, wdata1,
        output bus_in,
`ifdef BYTE_BUS_WAIT_EN
        output bus_rdy,
`endif
        input  ack0, ack1, rdata,
        input  bus_out, bus_oe, bus_phase,
        input  grant, busy
    );
endinterface

// File: rtl/byte_bus_arbiter.sv
// Round-robin arbiter sequencing two 32-bit requesters onto one byte bus.
// Define BYTE_BUS_WAIT_EN to add bus_rdy wait states in the data phase.
module byte_bus_arbiter #(
    parameter int BEATS = 4
) (
    input logic       clk,
    input logic       rst_n,
    byte_bus_if.master bus
);
    localparam int W  = 8 * BEATS;
    localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

    state_t         r_state;
    logic [BW-1:0]  r_beat;
    logic           r_ptr;
    logic           r_rw;
    logic [W-1:0]   r_addr;
    logic [W-1:0]   r_wdata;
    logic [W-1:0]   r_rdata;
    logic [7:0]     r_out;
    logic [7:0]     r_oe;
    logic [3:0]     r_phase;
    logic [1:0]     r_grant;
    logic           r_busy;
    logic           r_ack0;
    logic           r_ack1;

    logic           w_pick1;
    logic [BW-1:0]  w_next;
    logic           w_adv;

    // Requester 1 wins when alone, or on a tie when requester 0 went last.
    assign w_pick1 = bus.req1 & (~bus.req0 | ~r_ptr);
    assign w_next  = r_beat + 1'b1;
`ifdef BYTE_BUS_WAIT_EN
    assign w_adv   = bus.bus_rdy;
`else
    assign w_adv   = 1'b1;
`endif

    // Transaction sequencer; every output comes straight from a register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_beat  <= '0;
            r_ptr   <= 1'b1;
            r_rw    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_out   <= 8'h00;
            r_oe    <= 8'h00;
            r_phase <= 4'hF;
            r_grant <= 2'b00;
            r_busy  <= 1'b0;
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (bus.req0 | bus.req1) begin
                        r_state <= ADDR;
                        r_beat  <= '0;
                        r_ptr   <= w_pick1;
                        r_rw    <= w_pick1 ? bus.rw1 : bus.rw0;
                        r_addr  <= w_pick1 ? bus.addr1 : bus.addr0;
                        r_wdata <= w_pick1 ? bus.wdata1 : bus.wdata0;
                        r_out   <= w_pick1 ? bus.addr1[7:0] : bus.addr0[7:0];
                        r_oe    <= 8'hFF;
                        r_phase <= 4'h0;
                        r_grant <= w_pick1 ? 2'b10 : 2'b01;
                        r_busy  <= 1'b1;
                    end
                end
                ADDR: begin
                    if (r_beat == LAST) begin
                        r_state <= DATA;
                        r_beat  <= '0;
                        r_phase <= 4'(BEATS);
                        r_out   <= r_rw ? 8'h00 : r_wdata[7:0];
                        r_oe    <= r_rw ? 8'h00 : 8'hFF;
                    end else begin
                        r_beat  <= w_next;
                        r_phase <= 4'(w_next);
                        r_out   <= r_addr[8*w_next +: 8];
                    end
                end
                DATA: begin
                    if (w_adv) begin
                        if (r_rw) begin
                            r_rdata[8*r_beat +: 8] <= bus.bus_in;
                        end
                        if (r_beat == LAST) begin
                            r_state <= DONE;
                            r_beat  <= '0;
                            r_phase <= 4'(2 * BEATS);
                            r_out   <= 8'h00;
                            r_oe    <= 8'h00;
                            r_ack0  <= r_grant[0];
                            r_ack1  <= r_grant[1];
                        end else begin
                            r_beat  <= w_next;
                            r_phase <= 4'(BEATS) + 4'(w_next);
                            r_out   <= r_rw ? 8'h00 : r_wdata[8*w_next +: 8];
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_phase <= 4'hF;
                    r_grant <= 2'b00;
                    r_busy  <= 1'b0;
                    r_ack0  <= 1'b0;
                    r_ack1  <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.ack0      = r_ack0;
    assign bus.ack1      = r_ack1;
    assign bus.rdata     = r_rdata;
    assign bus.bus_out   = r_out;
    assign bus.bus_oe    = r_oe;
    assign bus.bus_phase = r_phase;
    assign bus.grant     = r_grant;
    assign bus.busy      = r_busy;
endmodule

// File: tb/tb_byte_bus_arbiter.sv
// Directed bench for byte_bus_arbiter: vector table plus corner sequences.
// The wait-state sequence is built only when BYTE_BUS_WAIT_EN is defined.
module tb_byte_bus_arbiter;
    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    byte_bus_if #(.BEATS(4)) bif ();

    byte_bus_arbiter #(.BEATS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif.master)
    );

    typedef struct {
        logic        who;
        logic        rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] bin;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_grant;
    } vec_t;

    vec_t vt [4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic [7:0] byt(input logic [31:0] w, input int k);
        return w[8*k +: 8];
    endfunction

    task automatic idle_inputs();
        bif.req0 = 0; bif.rw0 = 0; bif.addr0 = '0; bif.wdata0 = '0;
        bif.req1 = 0; bif.rw1 = 0; bif.addr1 = '0; bif.wdata1 = '0;
        bif.bus_in = 8'h00;
`ifdef BYTE_BUS_WAIT_EN
        bif.bus_rdy = 1'b1;
`endif
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        int          nack;
        int          ackpos;
        int          c;
        logic [1:0]  g [4];
        int          at [4];

        n_pass  = 0;
        n_total = 0;
        idle_inputs();
        rst_n = 1'b0;

        vt[0] = '{1'b0, 1'b0, 32'h1234_5678, 32'hDEAD_BEEF,
                  32'h0, 32'h0000_0000, 2'b01};
        vt[1] = '{1'b1, 1'b1, 32'h0000_0010, 32'h0,
                  32'h4433_2211, 32'h4433_2211, 2'b10};
        vt[2] = '{1'b0, 1'b1, 32'hA5A5_0001, 32'h0,
                  32'h0807_0605, 32'h0807_0605, 2'b01};
        vt[3] = '{1'b1, 1'b0, 32'hFFFF_FFFE, 32'h0102_0304,
                  32'h0, 32'h0807_0605, 2'b10};

        // reset state
        tick();
        chk("rst_phase", 32'(bif.bus_phase), 32'hF);
        chk("rst_oe", 32'(bif.bus_oe), 32'h0);
        chk("rst_out", 32'(bif.bus_out), 32'h0);
        chk("rst_grant", 32'(bif.grant), 32'h0);
        chk("rst_busy", 32'(bif.busy), 32'h0);
        chk("rst_ack", 32'({bif.ack1, bif.ack0}), 32'h0);
        chk("rst_rdata", bif.rdata, 32'h0);
        rst_n = 1'b1;
        tick();

        // vector table
        for (int i = 0; i < 4; i++) begin
            if (vt[i].who) begin
                bif.req1 = 1; bif.rw1 = vt[i].rw;
                bif.addr1 = vt[i].addr; bif.wdata1 = vt[i].wdata;
            end else begin
                bif.req0 = 1; bif.rw0 = vt[i].rw;
                bif.addr0 = vt[i].addr; bif.wdata0 = vt[i].wdata;
            end
            tick();
            bif.req0 = 0; bif.req1 = 0;
            bif.addr0 = ~vt[i].addr; bif.wdata0 = ~vt[i].wdata;
            bif.addr1 = ~vt[i].addr; bif.wdata1 = ~vt[i].wdata;
            bif.rw0 = ~vt[i].rw; bif.rw1 = ~vt[i].rw;
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("v%0d_aout%0d", i, k), 32'(bif.bus_out),
                    32'(byt(vt[i].addr, k)));
                chk($sformatf("v%0d_aoe%0d", i, k), 32'(bif.bus_oe), 32'hFF);
                chk($sformatf("v%0d_aph%0d", i, k), 32'(bif.bus_phase), k);
                chk($sformatf("v%0d_agnt%0d", i, k), 32'(bif.grant),
                    32'(vt[i].exp_grant));
                tick();
            end
            for (int k = 0; k < 4; k++) begin
                bif.bus_in = byt(vt[i].bin, k);
                chk($sformatf("v%0d_dout%0d", i, k), 32'(bif.bus_out),
                    vt[i].rw ? 32'h0 : 32'(byt(vt[i].wdata, k)));
                chk($sformatf("v%0d_doe%0d", i, k), 32'(bif.bus_oe),
                    vt[i].rw ? 32'h0 : 32'hFF);
                chk($sformatf("v%0d_dph%0d", i, k), 32'(bif.bus_phase), 4 + k);
                tick();
            end
            chk($sformatf("v%0d_ack", i), 32'({bif.ack1, bif.ack0}),
                32'(vt[i].exp_grant));
            chk($sformatf("v%0d_rdata", i), bif.rdata, vt[i].exp_rdata);
            chk($sformatf("v%0d_donph", i), 32'(bif.bus_phase), 32'h8);
            chk($sformatf("v%0d_donoe", i), 32'(bif.bus_oe), 32'h0);
            chk($sformatf("v%0d_donbusy", i), 32'(bif.busy), 32'h1);
            tick();
            chk($sformatf("v%0d_idph", i), 32'(bif.bus_phase), 32'hF);
            chk($sformatf("v%0d_idgnt", i), 32'(bif.grant), 32'h0);
            chk($sformatf("v%0d_idbusy", i), 32'(bif.busy), 32'h0);
            chk($sformatf("v%0d_idack", i), 32'({bif.ack1, bif.ack0}), 32'h0);
            idle_inputs();
        end

        // req0 dropped during address beat 1
        bif.req0 = 1; bif.rw0 = 0;
        bif.addr0 = 32'h0000_00AB; bif.wdata0 = 32'h5555_AAAA;
        tick();
        tick();
        chk("drop_ph1", 32'(bif.bus_phase), 32'h1);
        bif.req0 = 0;
        nack = 0;
        ackpos = 0;
        for (int t = 1; t <= 15; t++) begin
            tick();
            if (bif.ack0) begin
                nack++;
                ackpos = t;
            end
        end
        chk("drop_nack", nack, 1);
        chk("drop_ackpos", ackpos, 7);
        chk("drop_idle", 32'(bif.bus_phase), 32'hF);

        // async reset during write data beat 2
        bif.req0 = 1; bif.rw0 = 0;
        bif.addr0 = 32'h1111_2222; bif.wdata0 = 32'h3333_4444;
        tick();
        bif.req0 = 0;
        for (int t = 0; t < 6; t++) tick();
        chk("mrst_pre_ph", 32'(bif.bus_phase), 32'h6);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_ph", 32'(bif.bus_phase), 32'hF);
        chk("mrst_oe", 32'(bif.bus_oe), 32'h0);
        chk("mrst_out", 32'(bif.bus_out), 32'h0);
        chk("mrst_gnt", 32'(bif.grant), 32'h0);
        chk("mrst_busy", 32'(bif.busy), 32'h0);
        nack = 0;
        for (int t = 0; t < 3; t++) begin
            tick();
            if (bif.ack0 | bif.ack1) nack++;
        end
        rst_n = 1'b1;
        tick();
        bif.req0 = 1; bif.rw0 = 0;
        bif.addr0 = 32'hCAFE_0042; bif.wdata0 = 32'h0;
        tick();
        bif.req0 = 0;
        chk("mrst_restart_ph", 32'(bif.bus_phase), 32'h0);
        chk("mrst_restart_out", 32'(bif.bus_out), 32'h42);
        for (int t = 0; t < 9; t++) begin
            tick();
            if (bif.ack0 | bif.ack1) nack++;
        end
        chk("mrst_nack", nack, 1);

        // both requesters held: round-robin alternation
        do_reset();
        bif.req0 = 1; bif.rw0 = 0; bif.addr0 = 32'h0A0A_0A0A;
        bif.req1 = 1; bif.rw1 = 0; bif.addr1 = 32'h0B0B_0B0B;
        nack = 0;
        c = 0;
        while (nack < 4 && c < 60) begin
            tick();
            c++;
            if (bif.ack0 | bif.ack1) begin
                g[nack]  = {bif.ack1, bif.ack0};
                at[nack] = c;
                nack++;
            end
        end
        bif.req0 = 0; bif.req1 = 0;
        chk("rr_nack", nack, 4);
        if (nack == 4) begin
            chk("rr_first_at", at[0], 9);
            chk("rr_g0", 32'(g[0]), 32'h1);
            chk("rr_g1", 32'(g[1]), 32'h2);
            chk("rr_g2", 32'(g[2]), 32'h1);
            chk("rr_g3", 32'(g[3]), 32'h2);
            chk("rr_gap1", at[1] - at[0], 10);
            chk("rr_gap2", at[2] - at[1], 10);
            chk("rr_gap3", at[3] - at[2], 10);
        end
        tick();
        tick();
        idle_inputs();

`ifdef BYTE_BUS_WAIT_EN
        // bus_rdy low for 3 cycles in read data beat 1
        bif.req1 = 1; bif.rw1 = 1; bif.addr1 = 32'h0;
        tick();
        bif.req1 = 0;
        for (int t = 0; t < 4; t++) tick();
        bif.bus_in = 8'hAA;
        chk("w_ph4", 32'(bif.bus_phase), 32'h4);
        tick();
        bif.bus_rdy = 1'b0;
        bif.bus_in = 8'h99;
        for (int t = 0; t < 3; t++) begin
            chk($sformatf("w_hold%0d", t), 32'(bif.bus_phase), 32'h5);
            chk($sformatf("w_oe%0d", t), 32'(bif.bus_oe), 32'h0);
            tick();
        end
        bif.bus_rdy = 1'b1;
        bif.bus_in = 8'hBB;
        chk("w_hold3", 32'(bif.bus_phase), 32'h5);
        tick();
        bif.bus_in = 8'hCC;
        chk("w_ph6", 32'(bif.bus_phase), 32'h6);
        tick();
        bif.bus_in = 8'hDD;
        tick();
        chk("w_ack", 32'({bif.ack1, bif.ack0}), 32'h2);
        chk("w_rdata", bif.rdata, 32'hDDCC_BBAA);
        tick();
        idle_inputs();
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
